// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture path: RGB111 bit layout,
// RGB565 source bit positions and the capture FSM state encoding.
package cam_capture_pkg;

   localparam int unsigned PIX_R = 2;
   localparam int unsigned PIX_G = 1;
   localparam int unsigned PIX_B = 0;

   // MSB of each colour field: R and G from the first byte, B from the second
   localparam int unsigned SRC_R = 7;
   localparam int unsigned SRC_G = 2;
   localparam int unsigned SRC_B = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SYNC    = 2'd1,
      ST_CAPTURE = 2'd2
   } cap_state_t;

   function automatic logic [2:0] pack_rgb111(input logic [7:0] first,
                                              input logic [7:0] second);
      logic [2:0] pix;
      pix        = '0;
      pix[PIX_R] = first[SRC_R];
      pix[PIX_G] = first[SRC_G];
      pix[PIX_B] = second[SRC_B];
      return pix;
   endfunction

endpackage

// File: rtl/cam_capture_sync_in.sv
// Input register stage for the camera bus plus href falling-edge detect.
// All downstream decisions use these registered copies only.
module cam_sync_in (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       href,
   input  logic [7:0] cam_data,
   output logic       vs_q,
   output logic       hr_q,
   output logic [7:0] d_q,
   output logic       hr_fall
);

   logic hr_q_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         vs_q      <= 1'b0;
         hr_q      <= 1'b0;
         d_q       <= 8'h00;
         hr_q_prev <= 1'b0;
      end else begin
         vs_q      <= vsync;
         hr_q      <= href;
         d_q       <= cam_data;
         hr_q_prev <= hr_q;
      end
   end

   assign hr_fall = hr_q_prev & ~hr_q;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: pairs RGB565 bytes into RGB111 pixels and writes them
// row-major into the frame buffer, flagging frame end and dropped data.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | after reset; waiting for vsync high so we never start mid-frame
// ST_SYNC    | vsync high (between frames); falling vsync starts a new frame
// ST_CAPTURE | storing pixels; rising vsync ends the frame
module cam_capture
   import cam_capture_pkg::*;
#(
   parameter int AW    = 15,
   parameter int DW    = 3,
   parameter int IMG_W = 160,
   parameter int IMG_H = 120
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    cam_data,
   output logic [AW-1:0] addr_in,
   output logic [DW-1:0] data_in,
   output logic          regwrite,
   output logic          frame_done,
   output logic          ovf
);

   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = $clog2(IMG_H + 1);

   logic          vs_q;
   logic          hr_q;
   logic [7:0]    d_q;
   logic          hr_fall;

   cap_state_t    state_q;
   cap_state_t    state_d;
   logic          start_frame;
   logic          end_frame;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          phase;
   logic [7:0]    first_q;
   logic [AW-1:0] base;
   logic          capturing;
   logic          pix_fits;

   cam_sync_in u_sync_in (
      .clk      (clk),
      .reset    (reset),
      .vsync    (vsync),
      .href     (href),
      .cam_data (cam_data),
      .vs_q     (vs_q),
      .hr_q     (hr_q),
      .d_q      (d_q),
      .hr_fall  (hr_fall)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (vs_q) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (!vs_q) begin
               state_d     = ST_CAPTURE;
               start_frame = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (vs_q) begin
               state_d   = ST_SYNC;
               end_frame = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign capturing = (state_q == ST_CAPTURE);
   assign pix_fits  = (col < CW'(IMG_W)) && (row < RW'(IMG_H));

   // Capture keeps running on the edge that ends the frame, so a pixel
   // completing together with the vsync rise is still stored.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_in    <= '0;
         data_in    <= '0;
         regwrite   <= 1'b0;
         frame_done <= 1'b0;
         ovf        <= 1'b0;
         col        <= '0;
         row        <= '0;
         phase      <= 1'b0;
         first_q    <= 8'h00;
         base       <= '0;
      end else begin
         regwrite   <= 1'b0;
         frame_done <= end_frame;
         if (start_frame) begin
            col   <= '0;
            row   <= '0;
            phase <= 1'b0;
            ovf   <= 1'b0;
            base  <= '0;
         end else if (capturing) begin
            if (hr_q) begin
               phase <= ~phase;
               if (!phase) begin
                  first_q <= d_q;
               end else if (pix_fits) begin
                  regwrite <= 1'b1;
                  addr_in  <= base + AW'(col);
                  data_in  <= pack_rgb111(first_q, d_q);
                  col      <= col + 1'b1;
               end else begin
                  ovf <= 1'b1;
               end
            end else begin
               phase <= 1'b0;
               if (phase) ovf <= 1'b1;
               // empty lines leave row and base untouched
               if (hr_fall && (col != '0)) begin
                  col <= '0;
                  if (row < RW'(IMG_H)) begin
                     row  <= row + 1'b1;
                     base <= base + AW'(IMG_W);
                  end
               end
            end
         end
      end
   end

endmodule
